// File: rtl/aes_gcm_stream_packer.sv
// Packs 32-bit host words MSB-first into 128-bit AAD/payload beats for the GCM core.
// Beat boundaries, keep masks and last flags follow the byte lengths loaded at start.
module aes_gcm_stream_packer (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [63:0]  len_aad_bits,
  input  logic [63:0]  len_pld_bits,
  input  logic         s_valid,
  input  logic [31:0]  s_data,
  output logic         s_ready,
  output logic         aad_valid,
  input  logic         aad_ready,
  output logic [127:0] aad_data,
  output logic [15:0]  aad_keep,
  output logic         aad_last,
  output logic         din_valid,
  input  logic         din_ready,
  output logic [127:0] din_data,
  output logic [15:0]  din_keep,
  output logic         din_last,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {StIdle, StAad, StPld, StFin} state_e;

  state_e       state_q, state_d;
  logic         start_q;
  logic [60:0]  aad_rem_q, aad_rem_d;
  logic [60:0]  pld_rem_q, pld_rem_d;
  logic [1:0]   widx_q, widx_d;
  logic [127:0] asm_q, asm_d;
  logic [15:0]  keep_q, keep_d;
  logic         last_q, last_d;
  logic         pend_q, pend_d;

  logic         in_aad, in_pld, start_pulse, accept, beat_hs;
  logic [60:0]  cur_rem, rem_nxt;
  logic [2:0]   n;
  logic [3:0]   slot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      start_q   <= 1'b0;
      aad_rem_q <= '0;
      pld_rem_q <= '0;
      widx_q    <= '0;
      asm_q     <= '0;
      keep_q    <= '0;
      last_q    <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_q   <= start;
      aad_rem_q <= aad_rem_d;
      pld_rem_q <= pld_rem_d;
      widx_q    <= widx_d;
      asm_q     <= asm_d;
      keep_q    <= keep_d;
      last_q    <= last_d;
      pend_q    <= pend_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    aad_rem_d = aad_rem_q;
    pld_rem_d = pld_rem_q;
    widx_d    = widx_q;
    asm_d     = asm_q;
    keep_d    = keep_q;
    last_d    = last_q;
    pend_d    = pend_q;
    slot      = '0;

    in_aad      = (state_q == StAad);
    in_pld      = (state_q == StPld);
    start_pulse = start && !start_q;
    s_ready     = (in_aad || in_pld) && !pend_q;
    accept      = s_valid && s_ready;
    beat_hs     = pend_q && ((in_aad && aad_ready) || (in_pld && din_ready));
    cur_rem     = in_aad ? aad_rem_q : pld_rem_q;
    n           = (cur_rem >= 61'd4) ? 3'd4 : cur_rem[2:0];
    rem_nxt     = cur_rem - {58'd0, n};

    unique case (state_q)
      StIdle: begin
        if (start_pulse) begin
          aad_rem_d = len_aad_bits[63:3];
          pld_rem_d = len_pld_bits[63:3];
          if (len_aad_bits[63:3] != '0)      state_d = StAad;
          else if (len_pld_bits[63:3] != '0) state_d = StPld;
          else                               state_d = StFin;
        end
      end
      StAad, StPld: begin
        if (accept) begin
          for (int b = 0; b < 4; b++) begin
            if (3'(b) < n) begin
              slot = {widx_q, 2'b00} + 4'(b);
              // ~slot == 15 - slot: byte 0 of the beat sits at the top
              asm_d[{~slot, 3'b000} +: 8] = s_data[8*(3-b) +: 8];
              keep_d[~slot]               = 1'b1;
            end
          end
          if (in_aad) aad_rem_d = rem_nxt;
          else        pld_rem_d = rem_nxt;
          widx_d = widx_q + 2'd1;
          if (widx_q == 2'd3 || rem_nxt == '0) begin
            pend_d = 1'b1;
            widx_d = '0;
            last_d = (rem_nxt == '0);
          end
        end
        if (beat_hs) begin
          // Clearing on handshake gives the next beat zeroed unloaded bytes
          pend_d = 1'b0;
          asm_d  = '0;
          keep_d = '0;
          last_d = 1'b0;
          if (last_q) begin
            if (in_aad && pld_rem_q != '0) state_d = StPld;
            else                           state_d = StFin;
          end
        end
      end
      StFin: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign aad_valid = in_aad && pend_q;
  assign aad_data  = in_aad ? asm_q : '0;
  assign aad_keep  = in_aad ? keep_q : '0;
  assign aad_last  = in_aad && last_q;
  assign din_valid = in_pld && pend_q;
  assign din_data  = in_pld ? asm_q : '0;
  assign din_keep  = in_pld ? keep_q : '0;
  assign din_last  = in_pld && last_q;
  assign busy      = in_aad || in_pld;
  assign done      = (state_q == StFin);

endmodule

// File: tb/tb_aes_gcm_stream_packer.sv
// Directed bench for aes_gcm_stream_packer with hand-computed beats.
module tb_aes_gcm_stream_packer;

  logic         clk, rst_n, start;
  logic [63:0]  len_aad_bits, len_pld_bits;
  logic         s_valid, s_ready;
  logic [31:0]  s_data;
  logic         aad_valid, aad_ready, aad_last;
  logic [127:0] aad_data;
  logic [15:0]  aad_keep;
  logic         din_valid, din_ready, din_last;
  logic [127:0] din_data;
  logic [15:0]  din_keep;
  logic         busy, done;

  int tests = 0;
  int fails = 0;

  aes_gcm_stream_packer dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .len_aad_bits(len_aad_bits), .len_pld_bits(len_pld_bits),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .aad_valid(aad_valid), .aad_ready(aad_ready), .aad_data(aad_data),
    .aad_keep(aad_keep), .aad_last(aad_last),
    .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data),
    .din_keep(din_keep), .din_last(din_last),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    tests++;
    fails++;
    $error("FAIL %s observed=timeout expected=handshake", tag);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [63:0] la, input logic [63:0] lp);
    len_aad_bits = la;
    len_pld_bits = lp;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] d, input string tag);
    bit ok = 0;
    s_valid = 1'b1;
    s_data  = d;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (s_ready) ok = 1;
    end
    if (ok) step();
    else timeout(tag);
    s_valid = 1'b0;
  endtask

  // sel: 0 = AAD stream, 1 = payload stream
  task automatic expect_beat(input bit sel, input logic [127:0] ed, input logic [15:0] ek,
                             input logic el, input string tag);
    bit ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (sel ? din_valid : aad_valid) ok = 1;
    end
    if (!ok) begin
      timeout(tag);
    end else begin
      chk({tag, ".data"}, sel ? din_data : aad_data, ed);
      chk({tag, ".keep"}, 128'(sel ? din_keep : aad_keep), 128'(ek));
      chk({tag, ".last"}, 128'(sel ? din_last : aad_last), 128'(el));
      chk({tag, ".other_valid"}, 128'(sel ? aad_valid : din_valid), 128'(0));
      chk({tag, ".s_ready"}, 128'(s_ready), 128'(0));
      if (sel) din_ready = 1'b1;
      else     aad_ready = 1'b1;
      step();
      aad_ready = 1'b0;
      din_ready = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = '0;
    aad_ready = 1'b0; din_ready = 1'b0; len_aad_bits = '0; len_pld_bits = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.s_ready", 128'(s_ready), 128'(0));
    chk("rst.valids", 128'({aad_valid, din_valid, aad_last, din_last}), 128'(0));
    chk("rst.busy_done", 128'({busy, done}), 128'(0));
    chk("rst.aad_data", aad_data, 128'(0));
    chk("rst.din_keep", 128'({aad_keep, din_keep}), 128'(0));
    rst_n = 1'b1;
    step();

    // AAD 160 bits, no payload
    pulse_start(64'd160, 64'd0);
    chk("a.busy", 128'(busy), 128'(1));
    chk("a.s_ready", 128'(s_ready), 128'(1));
    push_word(32'h00010203, "a.w1");
    push_word(32'h04050607, "a.w2");
    push_word(32'h08090A0B, "a.w3");
    push_word(32'h0C0D0E0F, "a.w4");
    expect_beat(0, 128'h000102030405060708090A0B0C0D0E0F, 16'hFFFF, 1'b0, "a.b1");
    push_word(32'h10111213, "a.w5");
    expect_beat(0, {32'h10111213, 96'h0}, 16'hF000, 1'b1, "a.b2");
    chk("a.done", 128'({done, busy}), 128'(2'b10));
    step();
    chk("a.idle", 128'({done, busy}), 128'(0));

    // Both sections empty
    step();
    pulse_start(64'd0, 64'd0);
    chk("e.done_t1", 128'({done, busy, s_ready}), 128'(3'b100));
    step();
    chk("e.idle_t2", 128'({done, busy, s_ready, aad_valid, din_valid}), 128'(0));

    // Payload only, 33 bytes
    step();
    pulse_start(64'd0, 64'd264);
    for (int k = 0; k < 4; k++) push_word(32'h20212223 + 32'h04040404 * k, "p.w");
    expect_beat(1, 128'h202122232425262728292A2B2C2D2E2F, 16'hFFFF, 1'b0, "p.b1");
    for (int k = 4; k < 8; k++) push_word(32'h20212223 + 32'h04040404 * k, "p.w");
    expect_beat(1, 128'h303132333435363738393A3B3C3D3E3F, 16'hFFFF, 1'b0, "p.b2");
    push_word(32'h40414243, "p.w9");
    expect_beat(1, {8'h40, 120'h0}, 16'h8000, 1'b1, "p.b3");
    chk("p.done", 128'(done), 128'(1));

    // One AAD byte, one payload byte
    step(); step();
    pulse_start(64'd8, 64'd8);
    push_word(32'hAABBCCDD, "s.w1");
    expect_beat(0, {8'hAA, 120'h0}, 16'h8000, 1'b1, "s.aad");
    chk("s.in_pld", 128'({busy, s_ready}), 128'(2'b11));
    push_word(32'h11223344, "s.w2");
    expect_beat(1, {8'h11, 120'h0}, 16'h8000, 1'b1, "s.din");
    chk("s.done", 128'(done), 128'(1));

    // Backpressure with a stray start edge
    step(); step();
    pulse_start(64'd0, 64'd128);
    push_word(32'hC0C1C2C3, "bp.w1");
    push_word(32'hC4C5C6C7, "bp.w2");
    push_word(32'hC8C9CACB, "bp.w3");
    push_word(32'hCCCDCECF, "bp.w4");
    for (int i = 0; i < 5; i++) begin
      start = (i == 1);
      len_pld_bits = 64'd8;
      @(negedge clk);
      chk("bp.hold_data", din_data, 128'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECF);
      chk("bp.hold_kl", 128'({din_keep, din_last, din_valid, s_ready}), 128'({16'hFFFF, 3'b110}));
      step();
    end
    start = 1'b0;
    expect_beat(1, 128'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECF, 16'hFFFF, 1'b1, "bp.beat");
    chk("bp.done", 128'(done), 128'(1));

    // Sub-byte payload length truncates to one byte
    step(); step();
    pulse_start(64'd0, 64'h0F);
    push_word(32'hDEADBEEF, "t.w1");
    expect_beat(1, {8'hDE, 120'h0}, 16'h8000, 1'b1, "t.beat");
    chk("t.done", 128'(done), 128'(1));

    // Reset while a beat is pending
    step(); step();
    pulse_start(64'd128, 64'd32);
    push_word(32'h01020304, "r.w1");
    push_word(32'h05060708, "r.w2");
    push_word(32'h090A0B0C, "r.w3");
    push_word(32'h0D0E0F10, "r.w4");
    @(negedge clk);
    chk("r.pending", 128'(aad_valid), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("r.outs", 128'({aad_valid, din_valid, aad_last, din_last, busy, done, s_ready}), 128'(0));
    chk("r.data", aad_data | din_data, 128'(0));
    step();
    rst_n = 1'b1;
    step();
    chk("r.idle", 128'({busy, done, s_ready, aad_keep}), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/aes_gcm_stream_packer.md
# aes_gcm_stream_packer

Host-side source for the AES-GCM datapath's AAD and payload streams. The block takes 32-bit host words, packs them MSB-first into 128-bit beats, and drives the `aad_*` and `din_*` valid/ready/last/keep interfaces. Section lengths come from the same `len_aad_bits`/`len_pld_bits` values handed to the GCM controller, so beat boundaries, `keep` masks and `last` flags match what the controller counts. It sits between the host register/DMA shim and the GCM core.

## Interface
Parameters: none. All widths are fixed by the GCM stream format.

Ports:
- `clk`  in  1  single clock; every flop is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  level input; its rising edge starts a message.
- `len_aad_bits`  in  64  AAD length in bits, sampled on the start edge.
- `len_pld_bits`  in  64  payload length in bits, sampled on the start edge.
- `s_valid`  in  1  host word valid.
- `s_data`  in  32  host word; byte 0 of the word is `[31:24]`.
- `s_ready`  out  1  host word accepted when `s_valid && s_ready`.
- `aad_valid`, `aad_ready`  out, in  1, 1  AAD beat handshake.
- `aad_data`  out  128  AAD beat; byte 0 of the beat is `[127:120]`.
- `aad_keep`  out  16  AAD byte-valid mask; `keep[15-i]` marks beat byte i.
- `aad_last`  out  1  beat carries the final AAD byte.
- `din_valid`, `din_ready`, `din_data`, `din_keep`, `din_last`  payload stream, same widths and rules as the AAD stream.
- `busy`  out  1  high in AAD or PLD state.
- `done`  out  1  one-cycle pulse when the message has been fully emitted.

## Operation
- Start edge: `start_pulse = start && !start_d`.
  - Accepted only in IDLE; ignored while `busy`.
  - On acceptance: `aad_rem <= len_aad_bits[63:3]` and `pld_rem <= len_pld_bits[63:3]`. Both are 61-bit byte counters; bits [2:0] are discarded.
- State machine states: IDLE, AAD, PLD, FIN.
- Transitions:
  - IDLE→AAD when `aad_rem != 0`.
  - IDLE→PLD when AAD is empty and payload is not.
  - IDLE→FIN when both are empty.
  - AAD→PLD (or FIN if the payload is empty) on the handshake of the beat with `aad_last`.
  - PLD→FIN on the handshake of the beat with `din_last`.
  - FIN→IDLE unconditionally; `done=1` during FIN.
- Word acceptance: `s_ready = (AAD|PLD) && !beat_pending`.
- Each accepted word contributes `n = min(4, rem)` bytes:
  - Bytes go into the assembly register at slot `4*widx`.
  - Unused bytes of the word are dropped.
  - `rem` decrements by `n`; `widx` increments.
- Beat close: the beat closes when `widx` reaches 3 on acceptance, or when `rem - n == 0`.
  - On close: `beat_pending <= 1`, `widx <= 0`.
  - `last` is set iff `rem - n == 0`.
- Beat contents:
  - `keep` has one bit set per loaded byte, from the MSB down.
  - Bytes that were not loaded read as 0 in `data`.
- Routing:
  - In AAD state the pending beat appears only on `aad_*` and `din_valid=0`; in PLD state the reverse.
- Section separation:
  - Each section starts on a fresh beat and a fresh host word.
  - AAD and payload bytes never share a beat or a host word.
- Backpressure: while `valid && !ready`, the `data`, `keep` and `last` outputs hold stable.
- Reset mid-operation: everything returns to IDLE and buffered data is discarded.

## Timing
- Reset values:
  - `s_ready`, `aad_valid`, `din_valid`, `aad_last`, `din_last`, `busy` and `done` are all 0.
  - `aad_data`, `din_data`, `aad_keep` and `din_keep` are all 0.
  - State is IDLE; counters are 0.
- Start latency:
  - Start edge sampled at cycle t: `busy` and `s_ready` are high at t+1.
  - With both sections empty: FIN at t+1 (`done=1`), IDLE at t+2.
- Beat latency:
  - The word that closes a beat is accepted at cycle c; `valid` is high at c+1.
  - `s_ready` is low from c+1 until the cycle after the beat handshake.
  - Peak rate is one beat per 5 cycles for full beats.
- Final beat:
  - Final payload handshake at cycle h: FIN and `done` at h+1, IDLE at h+2.
  - A new start edge is accepted from h+2.
- Start edge during FIN: dropped. The host must keep `start` low for at least one cycle before the next edge.

## Test plan
- AAD=160 bits, PLD=0, words 0x00010203…0x10111213:
  - Required: AAD beat 1 has `keep=FFFF`, `last=0`, `data=00010203_…_0C0D0E0F`.
  - Required: AAD beat 2 has `keep=F000`, `last=1`, `data[127:96]=10111213`, remainder 0.
  - Then `done`; `din_valid` stays 0 throughout.
- AAD=0, PLD=0:
  - Required: `done` at t+1 and IDLE at t+2.
  - No valid output and `s_ready` never asserts.
- AAD=0, PLD=264 bits (33 bytes), 9 words:
  - Required: din beats with `keep` FFFF, FFFF, 8000 and `last` only on beat 3.
  - Beat 3 byte 0 is the top byte of word 9.
- AAD=8 bits, PLD=8 bits:
  - Required: two words consumed.
  - `aad_keep=8000`, `aad_last=1`, then `din_keep=8000`, `din_last=1`.
- `din_ready` held low 5 cycles while a beat is pending:
  - Required: `din_data`, `din_keep` and `din_last` stable; `s_ready=0`.
  - A start edge mid-message is ignored.
  - `rst_n` low mid-beat forces all outputs to 0 and IDLE.
- `len_pld_bits=0x0F`:
  - Required: treated as 1 byte, one beat with `keep=8000`.
